// File: rtl/chunked_seq_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder_if
//   Operand/result handshake bundle for chunked_seq_adder.
//
//   Operand side : in_valid, in_ready, a, b, cin (and sub when ADDER_SUB_EN
//                  is defined)
//   Result side  : out_valid, out_ready, sum, cout, ovf
//   Status       : busy
//
//   Modports:
//     master - the block feeding operands and consuming results
//     slave  - the adder itself
//
//   Build option: `define ADDER_SUB_EN adds the 1-bit "sub" operand signal.
// ---------------------------------------------------------------------------
interface chunked_seq_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

`ifdef ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
`endif
endinterface

// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle registered adder: adds two WIDTH-bit operands plus carry-in
//   CHUNK bits per clock, rippling the carry between cycles in a register.
//   The result (sum, carry-out, signed overflow) is held until consumed.
//
//   Parameters:
//     WIDTH  - operand/sum width (>= 1)
//     CHUNK  - bits added per cycle; WIDTH must be a multiple of CHUNK
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous active-low reset (0 = in reset)
//     bus    - chunked_seq_adder_if.slave:
//                in_valid/in_ready + a, b, cin (+ sub) : operand handshake
//                out_valid/out_ready + sum, cout, ovf  : result handshake
//                busy                                  : high in BUSY/DONE
//
//   Build option:
//     ADDER_SUB_EN - adds the "sub" operand; sub=1 computes a - b
//                    (b inverted, carry-in forced to 1, cin ignored).
//                    Undefined: add-only.
//
//   Timing: out_valid rises NCHUNK cycles after the accepting edge; the
//   result is dropped on the edge where out_ready=1, and the next operand
//   is accepted one cycle later (initiation interval NCHUNK+2).
// ---------------------------------------------------------------------------
module chunked_seq_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                clk,
    input  logic                reset,
    chunked_seq_adder_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("chunked_seq_adder: WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               carry_q,     carry_d;
    logic [WIDTH-1:0]   a_op_q,      a_op_d;
    logic [WIDTH-1:0]   b_op_q,      b_op_d;   // b already in effective form
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;

    // Effective operand/carry at the input. Storing b_eff and the effective
    // carry captures the sub selection at acceptance, so no separate sub
    // register is needed.
    logic [WIDTH-1:0]   b_eff_in;
    logic               cin_eff_in;

`ifdef ADDER_SUB_EN
    assign b_eff_in   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff_in = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_eff_in   = bus.b;
    assign cin_eff_in = bus.cin;
`endif

    // One chunk of the addition, with an extra bit for the carry out.
    logic [CHUNK:0] chunk_res;
    assign chunk_res = {1'b0, a_op_q[idx_q*CHUNK +: CHUNK]}
                     + {1'b0, b_op_q[idx_q*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_op_d      = a_op_q;
        b_op_d      = b_op_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_op_d     = bus.a;
                    b_op_d     = b_eff_in;
                    carry_d    = cin_eff_in;
                    idx_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            BUSY: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d                     = chunk_res[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d      = chunk_res[CHUNK];
                    // sum_d already holds the final MSB at this point.
                    ovf_d       = (a_op_q[WIDTH-1] == b_op_q[WIDTH-1]) &&
                                  (sum_d[WIDTH-1]  != a_op_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                // in_ready stays low here: the next operand is only taken
                // from IDLE, one cycle after the result is consumed.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_op_q      <= '0;
            b_op_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_op_q      <= a_op_d;
            b_op_q      <= b_op_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder
//   Scoreboard bench for chunked_seq_adder (WIDTH=8, CHUNK=2). Stimulus
//   pushes hand-computed expected results; a forked monitor pops and
//   compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_seq_adder_if #(.WIDTH(WIDTH)) bus();

    chunked_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: a transfer happens on the next rising edge whenever
    // out_valid && out_ready is seen on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                exp_t e;
                if (sbq.size() == 0) begin
                    chk("unexpected_result", {22'b0, bus.cout, bus.ovf, bus.sum}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk({"result_", e.tag}, {22'b0, bus.cout, bus.ovf, bus.sum},
                        {22'b0, e.cout, e.ovf, e.sum});
                end
            end
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input bit push,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input string tag, output int acc);
        exp_t e;
        int   k;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
`ifdef ADDER_SUB_EN
        bus.sub      = sub;
`endif
        if (push) begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.tag = tag;
            sbq.push_back(e);
        end
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (k == 100) chk({"accept_timeout_", tag}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Full add with out_ready=1: accept, check latency, let result drain.
    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                       input string tag);
        int acc, lat;
        issue(a, b, cin, sub, 1'b1, es, ec, eo, tag, acc);
        wait_valid(lat);
        chk({"latency_", tag}, lat, NCHUNK);
        @(posedge clk);
        #1;
        chk({"drop_valid_", tag}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int  acc1, acc2, lat;
        bit  saw_valid;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum",       bus.sum,       0);
        chk("rst_cout",      bus.cout,      0);
        chk("rst_ovf",       bus.ovf,       0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_in_ready",  bus.in_ready,  1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency and handshake status
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, "5a_3c", acc1);
        chk("busy_after_accept",     bus.busy,     1);
        chk("in_ready_after_accept", bus.in_ready, 0);
        wait_valid(lat);
        chk("latency_5a_3c", lat, NCHUNK);
        @(posedge clk);
        #1;
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_in_ready",  bus.in_ready,  1);
        chk("idle_busy",      bus.busy,      0);

        // Carry ripple across every chunk boundary and overflow cases
        run(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
        run(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "7f_00_c1");
        run(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "aa_55_c1");
        run(8'h33, 8'h44, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0, "33_44_c1");

        // Backpressure: result held while out_ready=0
        bus.out_ready = 1'b0;
        issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, "bp_80_80", acc1);
        wait_valid(lat);
        chk("latency_bp", lat, NCHUNK);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_sum",       bus.sum,       8'h00);
            chk("bp_cout",      bus.cout,      1);
            chk("bp_ovf",       bus.ovf,       1);
            chk("bp_in_ready",  bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", bus.out_valid, 0);

        // in_valid held through BUSY/DONE: second op waits for IDLE
        issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, "01_02", acc1);
        issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, "11_22", acc2);
        chk("initiation_interval", acc2 - acc1, NCHUNK + 2);
        wait_valid(lat);
        chk("latency_11_22", lat, NCHUNK);
        @(posedge clk);
        #1;

        // Reset during the second BUSY cycle aborts the operation
        issue(8'h44, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "abort", acc1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_sum",       bus.sum,       0);
        chk("abort_cout",      bus.cout,      0);
        chk("abort_ovf",       bus.ovf,       0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy",      bus.busy,      0);
        chk("abort_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_result", {31'b0, saw_valid}, 0);
        run(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "10_20");

`ifdef ADDER_SUB_EN
        run(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        run(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_cin_ignored");
        run(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, "sub0_add");
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
